// File: rtl/puf_test_ctrl.sv
// PUF statistical test sequencer: streams response bits to the tester, tallies
// per-test pass flags over ROUNDS rounds and writes the counts to result memory.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | zero counters for a new run
// COLLECT | forward accepted response bits to the tester
// TALLY   | accumulate tester pass flags, close the round
// STORE   | write one pass count per cycle to memory
// DONE    | results stored, waiting for rerun
module puf_test_ctrl #(
  parameter int N_TESTS        = 8,
  parameter int CNT_W          = 8,
  parameter int BITS_PER_ROUND = 20000,
  parameter int ROUNDS         = 255,
  parameter int ADDR_W         = 13,
  parameter int BASE_ADDR      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                resp_valid,
  input  logic                resp_bit,
  input  logic [N_TESTS-1:0]  test_result,
  output logic                test_bit,
  output logic                test_bit_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [CNT_W-1:0]    mem_din,
  output logic                busy,
  output logic                done
);

  localparam int BW = $clog2(BITS_PER_ROUND);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int SW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

  localparam logic [BW-1:0] BIT_LOAD = BW'(BITS_PER_ROUND - 1);
  localparam logic [RW-1:0] RND_LOAD = RW'(ROUNDS - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(N_TESTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_TALLY, S_STORE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]     rnd_cnt_q, rnd_cnt_d;
  logic [SW-1:0]     st_idx_q, st_idx_d;
  logic [CNT_W-1:0]  pass_cnt_q [N_TESTS];
  logic [CNT_W-1:0]  pass_cnt_d [N_TESTS];
  logic              test_bit_q, test_bit_d;
  logic              tb_valid_q, tb_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rnd_cnt_q  <= '0;
      st_idx_q   <= '0;
      test_bit_q <= 1'b0;
      tb_valid_q <= 1'b0;
      for (int i = 0; i < N_TESTS; i++) pass_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rnd_cnt_q  <= rnd_cnt_d;
      st_idx_q   <= st_idx_d;
      test_bit_q <= test_bit_d;
      tb_valid_q <= tb_valid_d;
      for (int i = 0; i < N_TESTS; i++) pass_cnt_q[i] <= pass_cnt_d[i];
    end
  end

  // Bit and round counters run down from their load value; terminal count is zero.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rnd_cnt_d  = rnd_cnt_q;
    st_idx_d   = st_idx_q;
    test_bit_d = test_bit_q;
    tb_valid_d = 1'b0;
    for (int i = 0; i < N_TESTS; i++) pass_cnt_d[i] = pass_cnt_q[i];

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bit_cnt_d = BIT_LOAD;
        rnd_cnt_d = RND_LOAD;
        st_idx_d  = '0;
        for (int i = 0; i < N_TESTS; i++) pass_cnt_d[i] = '0;
        state_d   = S_COLLECT;
      end
      S_COLLECT: begin
        if (resp_valid) begin
          test_bit_d = resp_bit;
          tb_valid_d = 1'b1;
          if (bit_cnt_q == '0) begin
            bit_cnt_d = BIT_LOAD;
            state_d   = S_TALLY;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_TALLY: begin
        for (int i = 0; i < N_TESTS; i++) begin
          if (test_result[i] && (pass_cnt_q[i] != {CNT_W{1'b1}}))
            pass_cnt_d[i] = pass_cnt_q[i] + 1'b1;
        end
        if (rnd_cnt_q == '0) begin
          state_d = S_STORE;
        end else begin
          rnd_cnt_d = rnd_cnt_q - 1'b1;
          state_d   = S_COLLECT;
        end
      end
      S_STORE: begin
        if (st_idx_q == IDX_LAST) state_d = S_DONE;
        else                      st_idx_d = st_idx_q + 1'b1;
      end
      S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      tb_valid_d = 1'b0;
    end
  end

  // Abort suppresses the write in the cycle it arrives so no partial result lands.
  assign mem_we         = (state_q == S_STORE) && !abort;
  assign mem_waddr      = mem_we ? (ADDR_W'(BASE_ADDR) + ADDR_W'(st_idx_q)) : '0;
  assign mem_din        = mem_we ? pass_cnt_q[st_idx_q] : '0;
  assign busy           = (state_q == S_CLEAR) || (state_q == S_COLLECT) ||
                          (state_q == S_TALLY) || (state_q == S_STORE);
  assign done           = (state_q == S_DONE);
  assign test_bit       = test_bit_q;
  assign test_bit_valid = tb_valid_q;

endmodule

// File: tb/tb_puf_test_ctrl.sv
// Directed bench for puf_test_ctrl: table of full runs plus abort, reset and rerun sequences.
module tb_puf_test_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, resp_valid, resp_bit;
  logic [1:0]  test_result;

  logic        a_tb, a_tbv, a_we, a_busy, a_done;
  logic [12:0] a_waddr;
  logic [1:0]  a_din;
  logic        b_tb, b_tbv, b_we, b_busy, b_done;
  logic [12:0] b_waddr;
  logic [1:0]  b_din;

  logic        sel5;
  logic        o_tb, o_tbv, o_we, o_busy, o_done;
  logic [12:0] o_waddr;
  logic [1:0]  o_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puf_test_ctrl #(.N_TESTS(2), .CNT_W(2), .BITS_PER_ROUND(4), .ROUNDS(3),
                  .ADDR_W(13), .BASE_ADDR(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp_bit(resp_bit), .test_result(test_result),
    .test_bit(a_tb), .test_bit_valid(a_tbv), .mem_we(a_we), .mem_waddr(a_waddr),
    .mem_din(a_din), .busy(a_busy), .done(a_done));

  puf_test_ctrl #(.N_TESTS(2), .CNT_W(2), .BITS_PER_ROUND(4), .ROUNDS(5),
                  .ADDR_W(13), .BASE_ADDR(16)) dut5 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .resp_valid(resp_valid), .resp_bit(resp_bit), .test_result(test_result),
    .test_bit(b_tb), .test_bit_valid(b_tbv), .mem_we(b_we), .mem_waddr(b_waddr),
    .mem_din(b_din), .busy(b_busy), .done(b_done));

  always_comb begin
    o_tb    = sel5 ? b_tb    : a_tb;
    o_tbv   = sel5 ? b_tbv   : a_tbv;
    o_we    = sel5 ? b_we    : a_we;
    o_waddr = sel5 ? b_waddr : a_waddr;
    o_din   = sel5 ? b_din   : a_din;
    o_busy  = sel5 ? b_busy  : a_busy;
    o_done  = sel5 ? b_done  : a_done;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    resp_valid = 1'b0; resp_bit = 1'b0; test_result = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input bit gap, input bit hold_start, input logic [1:0] tr,
                     input int e0, input int e1, input int nbits, input string tag);
    int  nw, mem0, mem1, pulses;
    bit  fin, prb;
    nw = 0; mem0 = -1; mem1 = -1; pulses = 0; fin = 1'b0;
    test_result = tr;
    start = 1'b1;
    resp_valid = 1'b1;
    resp_bit = 1'($urandom);
    prb = resp_bit;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, " start busy"}, int'(o_busy), 1);
        check({tag, " start done"}, int'(o_done), 0);
      end
      if (o_tbv) begin
        pulses++;
        check({tag, " test_bit"}, int'(o_tb), int'(prb));
      end
      if (o_we) begin
        check({tag, " waddr"}, int'(o_waddr), 16 + nw);
        if (nw == 0) mem0 = int'(o_din);
        else if (nw == 1) mem1 = int'(o_din);
        nw++;
      end
      if (o_done) fin = 1'b1;
      start = hold_start;
      resp_valid = gap ? ~resp_valid : 1'b1;
      resp_bit = 1'($urandom);
      prb = resp_bit;
    end
    start = 1'b0;
    check({tag, " done reached"}, int'(fin), 1);
    check({tag, " writes"}, nw, 2);
    check({tag, " mem16"}, mem0, e0);
    check({tag, " mem17"}, mem1, e1);
    check({tag, " bits"}, pulses, nbits);
  endtask

  typedef struct {
    bit         gap;
    bit         hold_start;
    bit         use5;
    logic [1:0] tr;
    int         e0;
    int         e1;
    int         nbits;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int we_seen;
    sel5 = 1'b0;

    vecs[0] = '{gap:0, hold_start:0, use5:0, tr:2'b01, e0:3, e1:0, nbits:12};
    vecs[1] = '{gap:0, hold_start:1, use5:0, tr:2'b10, e0:0, e1:3, nbits:12};
    vecs[2] = '{gap:1, hold_start:0, use5:0, tr:2'b01, e0:3, e1:0, nbits:12};
    vecs[3] = '{gap:0, hold_start:0, use5:1, tr:2'b11, e0:3, e1:3, nbits:20};
    vecs[4] = '{gap:0, hold_start:0, use5:0, tr:2'b00, e0:0, e1:0, nbits:12};
    vecs[5] = '{gap:1, hold_start:1, use5:1, tr:2'b10, e0:0, e1:3, nbits:20};
    vecs[6] = '{gap:0, hold_start:0, use5:0, tr:2'b11, e0:3, e1:3, nbits:12};

    // Reset values, then idle with responses present but no start.
    do_reset();
    check("rst busy",  int'(a_busy),  0);
    check("rst done",  int'(a_done),  0);
    check("rst we",    int'(a_we),    0);
    check("rst waddr", int'(a_waddr), 0);
    check("rst din",   int'(a_din),   0);
    check("rst tbv",   int'(a_tbv),   0);
    check("rst tb",    int'(a_tb),    0);
    resp_valid = 1'b1; resp_bit = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle busy", int'(a_busy), 0);
      check("idle tbv",  int'(a_tbv),  0);
    end

    for (int v = 0; v < 7; v++) begin
      do_reset();
      sel5 = vecs[v].use5;
      run(vecs[v].gap, vecs[v].hold_start, vecs[v].tr, vecs[v].e0, vecs[v].e1,
          vecs[v].nbits, $sformatf("vec%0d", v));
    end
    sel5 = 1'b0;

    // Abort in round 2, together with start, then a clean run.
    do_reset();
    test_result = 2'b01; start = 1'b1; resp_valid = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_we) we_seen++;
    end
    check("abort pre busy", int'(a_busy), 1);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    if (a_we) we_seen++;
    check("abort busy", int'(a_busy), 0);
    check("abort tbv",  int'(a_tbv),  0);
    check("abort done", int'(a_done), 0);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    if (a_we) we_seen++;
    check("abort idle", int'(a_busy), 0);
    check("abort no write", we_seen, 0);
    run(1'b0, 1'b0, 2'b01, 3, 0, 12, "post-abort");

    // Rerun from DONE clears done and produces fresh results.
    run(1'b0, 1'b0, 2'b10, 0, 3, 12, "rerun");

    // Reset after the first STORE write.
    do_reset();
    test_result = 2'b01; start = 1'b1; resp_valid = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 100 && we_seen == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_we) we_seen++;
    end
    check("store reached", we_seen, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid-store rst we",    int'(a_we),    0);
    check("mid-store rst waddr", int'(a_waddr), 0);
    check("mid-store rst din",   int'(a_din),   0);
    check("mid-store rst busy",  int'(a_busy),  0);
    check("mid-store rst done",  int'(a_done),  0);
    check("mid-store rst tbv",   int'(a_tbv),   0);
    we_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (a_we) we_seen++;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (a_we || a_busy) we_seen++;
    end
    check("no second write", we_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
